// File: rtl/dcache_ctrl_param.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// One CPU port serviced in the same cycle on a hit, one line-wide memory port.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl_param #(
   parameter int ADDR_W    = 32,
   parameter int WORD_W    = 32,
   parameter int LINE_BITS = 256,
   parameter int NUM_LINES = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    p1_addr_i,
   input  logic [WORD_W-1:0]    p1_data_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   output logic [WORD_W-1:0]    p1_data_o,
   output logic                 p1_stall_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`endif
);

   localparam int OFF_W  = $clog2(LINE_BITS/8);
   localparam int WLO    = $clog2(WORD_W/8);
   localparam int WPL    = LINE_BITS/WORD_W;
   localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_MISS, S_WRITEBACK, S_REFILL, S_REFILL_DONE
   } state_t;

   state_t               state_q, state_d;
   logic                 rst_dly_q;
   logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   logic                 line_we, tag_we, hit_evt, miss_evt;
   logic [LINE_BITS-1:0] line_wdata;

   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     req_tag, cur_tag;
   logic [WSEL_W-1:0]    wsel;
   logic [LINE_BITS-1:0] cur_line;
   logic [WORD_W-1:0]    cur_word;
   logic                 req, hit;
   logic                 unused_addr;

   assign idx         = p1_addr_i[OFF_W +: IDX_W];
   assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign wsel        = (WPL > 1) ? WSEL_W'(p1_addr_i >> WLO) : '0;
   assign req         = p1_MemRead_i | p1_MemWrite_i;
   assign cur_line    = data_q[idx];
   assign cur_tag     = tag_q[idx];
   assign cur_word    = cur_line[wsel*WORD_W +: WORD_W];
   assign hit         = valid_q[idx] && (cur_tag == req_tag);
   // Byte-offset bits below the word select never matter.
   assign unused_addr = ^p1_addr_i;

   // Next state, array updates and all outputs; reset and the cycle after it drive zeros
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      line_we      = 1'b0;
      tag_we       = 1'b0;
      line_wdata   = cur_line;
      hit_evt      = 1'b0;
      miss_evt     = 1'b0;
      p1_data_o    = '0;
      p1_stall_o   = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      if (rst_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Requests in the cycle right after reset are held off, not serviced.
               if (req && !rst_dly_q) begin
                  if (hit) begin
                     hit_evt = 1'b1;
                     if (p1_MemWrite_i) begin
                        line_wdata[wsel*WORD_W +: WORD_W] = p1_data_i;
                        line_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                     end else begin
                        p1_data_o = cur_word;
                     end
                  end else begin
                     p1_stall_o = 1'b1;
                     miss_evt   = 1'b1;
                     state_d    = S_MISS;
                  end
               end
            end
            S_MISS: begin
               p1_stall_o = 1'b1;
               state_d    = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
            end
            S_WRITEBACK: begin
               p1_stall_o   = 1'b1;
               mem_enable_o = 1'b1;
               mem_write_o  = 1'b1;
               mem_addr_o   = {cur_tag, idx, {OFF_W{1'b0}}};
               mem_data_o   = cur_line;
               if (mem_ack_i) state_d = S_REFILL;
            end
            S_REFILL: begin
               p1_stall_o   = 1'b1;
               mem_enable_o = 1'b1;
               mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
               if (mem_ack_i) begin
                  line_wdata   = mem_data_i;
                  line_we      = 1'b1;
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = S_REFILL_DONE;
               end
            end
            S_REFILL_DONE: begin
               p1_stall_o = 1'b1;
               state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM state and line status bits; reset clears valid/dirty only
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rst_dly_q <= 1'b1;
         valid_q   <= '0;
         dirty_q   <= '0;
      end else begin
         state_q   <= state_d;
         rst_dly_q <= 1'b0;
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
      end
   end

   // Tag and data arrays carry no reset
   always_ff @(posedge clk_i) begin
      if (line_we) data_q[idx] <= line_wdata;
      if (tag_we)  tag_q[idx]  <= req_tag;
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   // Saturating event counters
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_evt  && (hit_cnt_q  != 32'hFFFF_FFFF)) hit_cnt_d  = hit_cnt_q  + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_dcache_ctrl_param.sv
// Bench for dcache_ctrl_param (default parameters): hand-written miss/writeback/reset
// sequences, then a vector table run against an auto-acking memory model.
module tb_dcache_ctrl_param;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
   logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_enable_o, mem_write_o, mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

   always #5 clk = ~clk;

   dcache_ctrl_param #(.ADDR_W(32), .WORD_W(32), .LINE_BITS(256), .NUM_LINES(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] exp_q[$];
   logic [255:0] mem_model [logic [31:0]];
   bit          mem_auto = 1'b0;
   bit          man_ack = 1'b0;
   int          ack_delay = 0;
   int          wait_cnt = 0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_stalls;
   } vec_t;
   vec_t vecs[13];

   // Backing memory contents: word k of line a is 0xC0000000 | (a + 4k), except 0x400 word0.
   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hC000_0000 | (a + 32'(k*4));
      if (a == 32'h400) l[31:0] = 32'hDEADBEEF;
      return l;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return init_line(a);
   endfunction

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_set(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      p1_MemRead_i  = rd;
      p1_MemWrite_i = wr;
      p1_addr_i     = a;
      p1_data_i     = d;
   endtask

   // Waits (bounded) for stall to drop, pops the scoreboard on reads, checks stall count.
   task automatic wait_done(input int exp_st, input bit is_rd, input string nm);
      int          st = 0;
      bit          done = 1'b0;
      logic [31:0] e;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (p1_stall_o === 1'b0) begin
            done = 1'b1;
            if (is_rd) begin
               e = exp_q.pop_front();
               check({nm, "_data"}, 256'(p1_data_o), 256'(e));
            end
         end else begin
            st++;
            tick();
         end
      end
      if (!done) check({nm, "_timeout"}, 256'(p1_stall_o), 256'(0));
      check({nm, "_stalls"}, 256'(st), 256'(exp_st));
      tick();
      cpu_set(0, 0, 32'h0, 32'h0);
   endtask

   // Memory responder: sole driver of mem_ack_i / mem_data_i, stores write-backs.
   initial begin
      bit go;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack_i = 1'b0;
         go = mem_auto ? (mem_enable_o && (wait_cnt >= ack_delay)) : man_ack;
         if (go) begin
            mem_ack_i = 1'b1;
            if (mem_enable_o && mem_write_o) mem_model[mem_addr_o] = mem_data_o;
            else mem_data_i = line_of(mem_addr_o);
         end
         if (mem_enable_o && !go) wait_cnt++;
         else wait_cnt = 0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] wb_line;
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,          32'hC000_0408, 0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_2020, 32'hA1A1_A1A1,  32'h0,         4};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_2020, 32'h0,          32'hA1A1_A1A1, 0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_2024, 32'h0,          32'hC000_2024, 0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_3020, 32'h0,          32'hC000_3020, 5};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_2020, 32'h0,          32'hA1A1_A1A1, 4};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D,  32'h0,         4};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'h0BAD_F00D, 0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_0FF8, 32'h7777_7777,  32'h0,         0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FF8, 32'h0,          32'h7777_7777, 0};
      vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFE0, 32'h0,          32'hFFFF_FFE0, 5};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0FF8, 32'h0,          32'h7777_7777, 4};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'h0BAD_F00D, 0};

      // Reset with a read held: all outputs zero during reset and the cycle after.
      rst_i = 1'b1;
      cpu_set(1, 0, 32'h400, 32'h0);
      repeat (2) tick();
      @(negedge clk);
      check("rst_outs", 256'({p1_stall_o, mem_enable_o, mem_write_o, p1_data_o, mem_addr_o}), 256'(0));
      check("rst_mem_data", mem_data_o, 256'(0));
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_outs", 256'({p1_stall_o, mem_enable_o, mem_write_o, p1_data_o, mem_addr_o}), 256'(0));
      check("post_rst_mem_data", mem_data_o, 256'(0));

      // First miss on 0x400, manual ack.
      tick();
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("a_idle_miss", 256'({p1_stall_o, mem_enable_o}), 256'(2'b10));
      tick();
      @(negedge clk);
      check("a_miss", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(3'b100));
      tick();
      man_ack = 1'b1;
      @(negedge clk);
      check("a_refill", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(3'b110));
      check("a_refill_addr", 256'(mem_addr_o), 256'(32'h400));
      tick();
      man_ack = 1'b0;
      @(negedge clk);
      check("a_refill_done", 256'({p1_stall_o, mem_enable_o}), 256'(2'b10));
      wait_done(0, 1'b1, "a_hit400");

      // Write hit then read back.
      cpu_set(0, 1, 32'h404, 32'h1234_5678);
      @(negedge clk);
      check("b_wr_nostall", 256'(p1_stall_o), 256'(0));
      tick();
      cpu_set(1, 0, 32'h404, 32'h0);
      exp_q.push_back(32'h1234_5678);
      wait_done(0, 1'b1, "b_rd404");

      // Conflict miss on a dirty line: write-back then refill.
      cpu_set(1, 0, 32'h1404, 32'h0);
      exp_q.push_back(32'hC000_1404);
      @(negedge clk);
      check("c_idle_miss", 256'(p1_stall_o), 256'(1));
      tick();
      @(negedge clk);
      check("c_miss", 256'({p1_stall_o, mem_enable_o}), 256'(2'b10));
      tick();
      man_ack = 1'b1;
      wb_line = init_line(32'h400);
      wb_line[63:32] = 32'h1234_5678;
      @(negedge clk);
      check("c_wb_ctl", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(3'b111));
      check("c_wb_addr", 256'(mem_addr_o), 256'(32'h400));
      check("c_wb_word1", 256'(mem_data_o[63:32]), 256'(32'h1234_5678));
      check("c_wb_line", mem_data_o, wb_line);
      tick();
      @(negedge clk);
      check("c_refill_ctl", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(3'b110));
      check("c_refill_addr", 256'(mem_addr_o), 256'(32'h1400));
      tick();
      man_ack = 1'b0;
      wait_done(1, 1'b1, "c_rd1404");

      // Slow refill: ten cycles without ack, request and address held.
      cpu_set(1, 0, 32'h400, 32'h0);
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("d_idle_miss", 256'(p1_stall_o), 256'(1));
      tick();
      @(negedge clk);
      check("d_miss", 256'({p1_stall_o, mem_enable_o}), 256'(2'b10));
      tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("d_hold%0d", i),
               256'({p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o}), 256'({3'b110, 32'h400}));
         tick();
      end
      man_ack = 1'b1;
      @(negedge clk);
      check("d_ack_cycle_en", 256'({p1_stall_o, mem_enable_o}), 256'(2'b11));
      tick();
      man_ack = 1'b0;
      wait_done(1, 1'b1, "d_rd400");
      cpu_set(1, 0, 32'h404, 32'h0);
      exp_q.push_back(32'h1234_5678);
      wait_done(0, 1'b1, "d_rd404");

      // Reset during REFILL, late ack in the following cycle is ignored.
      cpu_set(1, 0, 32'h1400, 32'h0);
      tick();
      tick();
      @(negedge clk);
      check("e_refill_en", 256'(mem_enable_o), 256'(1));
      tick();
      rst_i = 1'b1;
      cpu_set(0, 0, 32'h0, 32'h0);
      @(negedge clk);
      check("e_rst_outs", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(0));
      tick();
      rst_i = 1'b0;
      man_ack = 1'b1;
      @(negedge clk);
      check("e_late_ack", 256'({p1_stall_o, mem_enable_o, mem_write_o}), 256'(0));
      tick();
      man_ack = 1'b0;
      @(negedge clk);
      check("e_idle", 256'({p1_stall_o, mem_enable_o, mem_addr_o}), 256'(0));
      tick();
      mem_auto  = 1'b1;
      ack_delay = 0;
      cpu_set(1, 0, 32'h400, 32'h0);
      exp_q.push_back(32'hDEADBEEF);
      wait_done(4, 1'b1, "e_remiss400");

      // Vector table against the auto-acking memory.
      for (int i = 0; i < 13; i++) begin
         cpu_set(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         if (!vecs[i].wr) exp_q.push_back(vecs[i].exp_data);
         wait_done(vecs[i].exp_stalls, !vecs[i].wr, $sformatf("vec%0d", i));
      end

`ifdef DCACHE_STATS_EN
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      @(negedge clk);
      check("s_rst_cnt", 256'({hit_cnt_o, miss_cnt_o}), 256'(0));
      tick();
      cpu_set(1, 0, 32'h400, 32'h0); exp_q.push_back(32'hDEADBEEF);  wait_done(4, 1'b1, "s0");
      cpu_set(1, 0, 32'h404, 32'h0); exp_q.push_back(32'h1234_5678); wait_done(0, 1'b1, "s1");
      cpu_set(1, 0, 32'h408, 32'h0); exp_q.push_back(32'hC000_0408); wait_done(0, 1'b1, "s2");
      cpu_set(1, 0, 32'h40C, 32'h0); exp_q.push_back(32'hC000_040C); wait_done(0, 1'b1, "s3");
      cpu_set(1, 0, 32'h2000, 32'h0); exp_q.push_back(32'hC000_2000); wait_done(4, 1'b1, "s4");
      @(negedge clk);
      check("s_hit_cnt", 256'(hit_cnt_o), 256'(5));
      check("s_miss_cnt", 256'(miss_cnt_o), 256'(2));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
